// File: rtl/sierpinski_chaos_game.sv
// Chaos-game point generator: each accepted random byte picks a triangle vertex and
// the current point moves halfway toward it; points leave on a valid/ready port.
module sierpinski_chaos_game #(
   parameter int COORD_W = 8,
   parameter int WARMUP  = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               run,
   input  logic               rnd_valid,
   input  logic [7:0]         rnd_data,
   output logic               rnd_ready,
   output logic               pt_valid,
   input  logic               pt_ready,
   output logic [COORD_W-1:0] pt_x,
   output logic [COORD_W-1:0] pt_y,
   output logic [1:0]         pt_vtx,
   output logic [7:0]         rej_cnt
);

   // state   | meaning
   // S_IDLE  | parked, point kept, waiting for run
   // S_FETCH | accepting random bytes (warm-up moves or rejects stay here)
   // S_HOLD  | presenting a point until pt_ready

   localparam int WW = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
   localparam logic [WW-1:0] WARM_MAX = WW'(WARMUP);
   localparam logic [COORD_W-1:0] C_X = {1'b1, {(COORD_W-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD} state_t;

   state_t             state;
   logic [WW-1:0]      warm_cnt;
   logic [1:0]         sel;
   logic [COORD_W-1:0] vx;
   logic [COORD_W-1:0] vy;
   logic [COORD_W:0]   sum_x;
   logic [COORD_W:0]   sum_y;
   logic [COORD_W-1:0] nx;
   logic [COORD_W-1:0] ny;
   logic               xfer;
   logic               rejected;
   logic               warm_done;
   logic               unused_rnd_bits;

   assign unused_rnd_bits = ^rnd_data[7:2];

   always_comb begin
      sel = rnd_data[1:0];
      vx  = '0;
      vy  = '0;
      case (sel)
         2'd1: vx = '1;
         2'd2: begin
            vx = C_X;
            vy = '1;
         end
         default: ;
      endcase
      // one extra bit keeps the sum exact; the shift floors
      sum_x     = {1'b0, pt_x} + {1'b0, vx};
      sum_y     = {1'b0, pt_y} + {1'b0, vy};
      nx        = sum_x[COORD_W:1];
      ny        = sum_y[COORD_W:1];
      xfer      = rnd_ready && rnd_valid;
      rejected  = (sel == 2'd3);
      warm_done = (warm_cnt == WARM_MAX);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         rnd_ready <= 1'b0;
         pt_valid  <= 1'b0;
         pt_x      <= '0;
         pt_y      <= '0;
         pt_vtx    <= 2'd0;
         rej_cnt   <= 8'd0;
         warm_cnt  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (run) begin
                  state     <= S_FETCH;
                  rnd_ready <= 1'b1;
               end
            end
            S_FETCH: begin
               if (xfer) begin
                  if (rejected) begin
                     if (rej_cnt != 8'hFF) rej_cnt <= rej_cnt + 8'd1;
                     if (!run) begin
                        state     <= S_IDLE;
                        rnd_ready <= 1'b0;
                     end
                  end else begin
                     pt_x <= nx;
                     pt_y <= ny;
                     if (!warm_done) begin
                        warm_cnt <= warm_cnt + 1'b1;
                        if (!run) begin
                           state     <= S_IDLE;
                           rnd_ready <= 1'b0;
                        end
                     end else begin
                        pt_vtx    <= sel;
                        state     <= S_HOLD;
                        rnd_ready <= 1'b0;
                        pt_valid  <= 1'b1;
                     end
                  end
               end else if (!run) begin
                  state     <= S_IDLE;
                  rnd_ready <= 1'b0;
               end
            end
            S_HOLD: begin
               // run is only looked at once the point has been taken
               if (pt_ready) begin
                  pt_valid <= 1'b0;
                  if (run) begin
                     state     <= S_FETCH;
                     rnd_ready <= 1'b1;
                  end else begin
                     state <= S_IDLE;
                  end
               end
            end
            default: begin
               state     <= S_IDLE;
               rnd_ready <= 1'b0;
               pt_valid  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sierpinski_chaos_game.sv
// Scoreboard bench for the chaos-game generator: two instances (WARMUP 0 and 8)
// share stimulus; a spec-level model predicts handshakes, coordinates and points.
module tb_sierpinski_chaos_game;

   logic       clk = 1'b0;
   logic       rst;
   logic       run;
   logic       rnd_valid;
   logic [7:0] rnd_data;
   logic       pt_ready;

   logic       rdy [2];
   logic       pv  [2];
   logic [7:0] px  [2];
   logic [7:0] py  [2];
   logic [1:0] vtx [2];
   logic [7:0] rej [2];

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   sierpinski_chaos_game #(.COORD_W(8), .WARMUP(0)) u_dut0 (
      .clk(clk), .rst(rst), .run(run), .rnd_valid(rnd_valid), .rnd_data(rnd_data),
      .rnd_ready(rdy[0]), .pt_valid(pv[0]), .pt_ready(pt_ready),
      .pt_x(px[0]), .pt_y(py[0]), .pt_vtx(vtx[0]), .rej_cnt(rej[0])
   );

   sierpinski_chaos_game #(.COORD_W(8), .WARMUP(8)) u_dut8 (
      .clk(clk), .rst(rst), .run(run), .rnd_valid(rnd_valid), .rnd_data(rnd_data),
      .rnd_ready(rdy[1]), .pt_valid(pv[1]), .pt_ready(pt_ready),
      .pt_x(px[1]), .pt_y(py[1]), .pt_vtx(vtx[1]), .rej_cnt(rej[1])
   );

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      int x;
      int y;
      int v;
   } pt_t;

   pt_t q0[$];
   pt_t q1[$];

   int mx[2], my[2], wc[2], mrej[2];
   bit epv[2], erdy[2];
   int wu[2]  = '{0, 8};
   int vxs[4] = '{0, 255, 128, 0};
   int vys[4] = '{0, 0, 255, 0};

   initial begin
      for (int i = 0; i < 2; i++) begin
         mx[i] = 0; my[i] = 0; wc[i] = 0; mrej[i] = 0; epv[i] = 0; erdy[i] = 0;
      end
   end

   always @(negedge clk) begin
      pt_t p;
      int  s;
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("pt_valid[%0d]", i), int'(pv[i]), int'(epv[i]));
         chk($sformatf("rnd_ready[%0d]", i), int'(rdy[i]), int'(erdy[i]));
         chk($sformatf("pt_x[%0d]", i), int'(px[i]), mx[i]);
         chk($sformatf("pt_y[%0d]", i), int'(py[i]), my[i]);
         chk($sformatf("rej_cnt[%0d]", i), int'(rej[i]), mrej[i]);
         if (rst) begin
            mx[i] = 0; my[i] = 0; wc[i] = 0; mrej[i] = 0; epv[i] = 0; erdy[i] = 0;
            if (i == 0) q0.delete(); else q1.delete();
         end else if (epv[i]) begin
            if (pt_ready) begin
               epv[i]  = 0;
               erdy[i] = run;
            end
         end else if (erdy[i] && rnd_valid) begin
            s = int'(rnd_data) % 4;
            if (s == 3) begin
               mrej[i] = (mrej[i] < 255) ? mrej[i] + 1 : 255;
               erdy[i] = run;
            end else begin
               mx[i] = (mx[i] + vxs[s]) / 2;
               my[i] = (my[i] + vys[s]) / 2;
               if (wc[i] < wu[i]) begin
                  wc[i]++;
                  erdy[i] = run;
               end else begin
                  p.x = mx[i]; p.y = my[i]; p.v = s;
                  if (i == 0) q0.push_back(p); else q1.push_back(p);
                  epv[i]  = 1;
                  erdy[i] = 0;
               end
            end
         end else begin
            erdy[i] = run;
         end
      end
   end

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      pt_t p;
      bit  empty;
      if (!rst && pt_ready) begin
         for (int i = 0; i < 2; i++) begin
            if (pv[i]) begin
               empty = (i == 0) ? (q0.size() == 0) : (q1.size() == 0);
               chk($sformatf("sb_point_expected[%0d]", i), int'(empty), 0);
               if (!empty) begin
                  p = (i == 0) ? q0.pop_front() : q1.pop_front();
                  chk($sformatf("sb_x[%0d]", i), int'(px[i]), p.x);
                  chk($sformatf("sb_y[%0d]", i), int'(py[i]), p.y);
                  chk($sformatf("sb_vtx[%0d]", i), int'(vtx[i]), p.v);
               end
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic feed(input logic [7:0] b, input int w);
      int n = 0;
      rnd_data  = b;
      rnd_valid = 1'b1;
      @(negedge clk);
      while (!rdy[w] && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk($sformatf("feed_wait[%0d]", w), int'(n < 50), 1);
      tick();
      rnd_valid = 1'b0;
   endtask

   int wx[9] = '{127, 191, 223, 239, 247, 251, 253, 254, 254};
   int sx;
   int sy;

   initial begin
      rst = 1'b1; run = 1'b1; pt_ready = 1'b1; rnd_valid = 1'b0; rnd_data = 8'd0;
      tick();
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("reset_valid", int'(pv[0]), 0);
      chk("reset_x", int'(px[0]), 0);
      tick();

      // basic path on the WARMUP=0 instance
      feed(8'h01, 0);
      @(negedge clk);
      chk("basic_b_valid", int'(pv[0]), 1);
      chk("basic_b_ready", int'(rdy[0]), 0);
      chk("basic_b_x", int'(px[0]), 127);
      chk("basic_b_y", int'(py[0]), 0);
      chk("basic_b_vtx", int'(vtx[0]), 1);
      tick();
      feed(8'h02, 0);
      @(negedge clk);
      chk("basic_c_x", int'(px[0]), 127);
      chk("basic_c_y", int'(py[0]), 127);
      chk("basic_c_vtx", int'(vtx[0]), 2);
      tick();
      feed(8'h00, 0);
      @(negedge clk);
      chk("basic_a_x", int'(px[0]), 63);
      chk("basic_a_y", int'(py[0]), 63);
      chk("basic_a_vtx", int'(vtx[0]), 0);
      tick();

      // rejection and rej_cnt saturation
      do_reset();
      feed(8'h03, 0);
      @(negedge clk);
      chk("rej_no_valid", int'(pv[0]), 0);
      chk("rej_x", int'(px[0]), 0);
      chk("rej_cnt1", int'(rej[0]), 1);
      tick();
      feed(8'h01, 0);
      @(negedge clk);
      chk("rej_then_b_x", int'(px[0]), 127);
      tick();
      rnd_data  = 8'h07;
      rnd_valid = 1'b1;
      repeat (310) tick();
      rnd_valid = 1'b0;
      @(negedge clk);
      chk("rej_sat0", int'(rej[0]), 255);
      chk("rej_sat8", int'(rej[1]), 255);
      tick();

      // backpressure
      do_reset();
      pt_ready = 1'b0;
      feed(8'h01, 0);
      repeat (5) begin
         @(negedge clk);
         chk("bp_valid", int'(pv[0]), 1);
         chk("bp_ready", int'(rdy[0]), 0);
         chk("bp_x", int'(px[0]), 127);
         chk("bp_vtx", int'(vtx[0]), 1);
         tick();
      end
      pt_ready = 1'b1;
      tick();
      @(negedge clk);
      chk("bp_back_fetch", int'(rdy[0]), 1);
      chk("bp_released", int'(pv[0]), 0);
      tick();

      // warm-up on the WARMUP=8 instance
      do_reset();
      for (int k = 0; k < 9; k++) begin
         feed(8'h01, 1);
         @(negedge clk);
         chk($sformatf("warm_valid_%0d", k), int'(pv[1]), (k == 8) ? 1 : 0);
         chk($sformatf("warm_x_%0d", k), int'(px[1]), wx[k]);
         chk($sformatf("warm_y_%0d", k), int'(py[1]), 0);
         tick();
      end

      // run drop in HOLD
      pt_ready = 1'b0;
      feed(8'h02, 0);
      sx = mx[0];
      sy = my[0];
      run = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("run_hold_valid", int'(pv[0]), 1);
         tick();
      end
      pt_ready = 1'b1;
      tick();
      tick();
      @(negedge clk);
      chk("run_idle_valid", int'(pv[0]), 0);
      chk("run_idle_ready", int'(rdy[0]), 0);
      chk("run_kept_x", int'(px[0]), sx);
      chk("run_kept_y", int'(py[0]), sy);
      tick();
      run = 1'b1;
      feed(8'h00, 0);
      @(negedge clk);
      chk("run_resume_x", int'(px[0]), sx / 2);
      chk("run_resume_y", int'(py[0]), sy / 2);
      tick();

      // reset while holding (63,63)
      do_reset();
      feed(8'h01, 0);
      tick();
      feed(8'h02, 0);
      tick();
      pt_ready = 1'b0;
      feed(8'h00, 0);
      @(negedge clk);
      chk("mid_hold_x", int'(px[0]), 63);
      chk("mid_hold_y", int'(py[0]), 63);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_valid", int'(pv[0]), 0);
      chk("mid_rst_x", int'(px[0]), 0);
      chk("mid_rst_y", int'(py[0]), 0);
      chk("mid_rst_rej", int'(rej[0]), 0);
      tick();
      pt_ready = 1'b1;
      feed(8'h01, 1);
      @(negedge clk);
      chk("warm_restart_valid", int'(pv[1]), 0);
      chk("warm_restart_x", int'(px[1]), 127);
      tick();

      // randomized traffic
      for (int c = 0; c < 4000; c++) begin
         rst       = ($urandom_range(0, 299) == 0);
         run       = ($urandom_range(0, 9) != 0);
         rnd_valid = ($urandom_range(0, 9) < 7);
         rnd_data  = 8'($urandom);
         pt_ready  = ($urandom_range(0, 9) < 6);
         tick();
      end
      rst = 1'b0; rnd_valid = 1'b0; pt_ready = 1'b1;
      repeat (4) tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/sierpinski_chaos_game.md
# sierpinski_chaos_game

Chaos-game point generator that sits directly downstream of the 8-bit LFSR random source in the Sierpinski design. Each accepted random byte selects one of three triangle vertices. Low-byte value 3 is rejected. The current point moves halfway toward the selected vertex. After a configurable warm-up, each new point is presented on a valid/ready output port for the plot/display stage.

## Interface
Parameters:
- COORD_W, default 8: coordinate width; MAX = 2^COORD_W − 1.
- WARMUP, default 8: number of accepted (non-rejected) moves discarded after reset before the first point is emitted; 0 means emit from the first move.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
- run  in  1  generator enable; low parks the block in IDLE with its point state kept.
- rnd_valid  in  1  random byte available; tie to the LFSR enable when fed from the free-running LFSR.
- rnd_data  in  8  random byte; only bits [1:0] are used.
- rnd_ready  out  1  block accepts rnd_data this cycle.
- pt_valid  out  1  pt_x/pt_y/pt_vtx hold a new point.
- pt_ready  in  1  downstream accepts the point.
- pt_x  out  COORD_W  point x coordinate.
- pt_y  out  COORD_W  point y coordinate.
- pt_vtx  out  2  vertex index used for this point: 0=A, 1=B, 2=C.
- rej_cnt  out  8  count of rejected bytes, saturating at 255.

## Operation
- Vertices:
  - A = (0, 0)
  - B = (MAX, 0)
  - C = (2^(COORD_W−1), MAX)
- Vertex select is sel = rnd_data[1:0]:
  - sel 0 → A, sel 1 → B, sel 2 → C.
  - sel 3 is rejected: the byte is consumed, the point is unchanged, rej_cnt increments (saturating), and no output is produced.
- Move rule: x' = (x + vx) >> 1 and y' = (y + vy) >> 1.
  - Sums are computed at COORD_W+1 bits; the shift floors; no overflow is possible.
- State machine:
  - IDLE: rnd_ready=0, pt_valid=0. Goes to FETCH when run=1.
  - FETCH: rnd_ready=1, pt_valid=0. Each cycle with rnd_valid=1 is a transfer:
    - sel 3: reject, stay in FETCH.
    - Otherwise, if warm_cnt < WARMUP: update the point, increment warm_cnt, stay in FETCH.
    - Otherwise: update the point, latch pt_vtx, go to HOLD.
    - If there is no transfer and run=0: go to IDLE.
    - A transfer in the same cycle as run=0 is still honoured. After that transfer the block goes to HOLD if a point is produced, otherwise to IDLE.
  - HOLD: pt_valid=1, rnd_ready=0. pt_x, pt_y and pt_vtx stay stable.
    - On pt_ready=1: go to FETCH if run=1, else to IDLE.
    - A run drop while in HOLD never withdraws pt_valid.
- pt_x and pt_y always show the current point register, including in IDLE and FETCH.
- warm_cnt saturates at WARMUP. It is cleared only by rst, not by run.
- Reset values:
  - state IDLE
  - pt_valid 0, rnd_ready 0
  - pt_x 0, pt_y 0, pt_vtx 0
  - rej_cnt 0, warm_cnt 0
- Reset mid-HOLD or mid-FETCH aborts the operation. Any pending point is dropped and the reset values apply after that edge.

## Timing
- rnd_ready and pt_valid are decoded from the state register only, with no combinational path from inputs.
- Latency: a transfer at edge N that produces a point gives pt_valid=1 with the new coordinates in the cycle after edge N.
- Throughput: at most one point per 2 cycles (FETCH, then HOLD with pt_ready=1).
- A transfer in FETCH updates pt_x/pt_y at the same edge, including warm-up moves.
- rej_cnt updates at the edge of the rejecting transfer.
- In HOLD the handshake completes at the edge where pt_valid=1 and pt_ready=1.

## Test plan
All scenarios use COORD_W=8, so A=(0,0), B=(255,0), C=(128,255).
- Basic path (WARMUP=0, run=1, pt_ready=1 after reset): feed 0x01, 0x02, 0x00. Points must be:
  - B: (127,0), pt_vtx=1
  - C: (127,127), pt_vtx=2
  - A: (63,63), pt_vtx=0
  - Each point appears one cycle after its transfer, with rnd_ready=0 during HOLD.
- Rejection: feed 0x03 then 0x01 from reset.
  - After 0x03: no pt_valid, point stays (0,0), rej_cnt=1.
  - After 0x01: point (127,0). Then feed 300 × 0x07; rej_cnt must read 255.
- Backpressure: hold pt_ready=0 for 5 cycles while pt_valid=1.
  - pt_x/pt_y/pt_vtx stay stable and rnd_ready stays 0.
  - On pt_ready=1 the block returns to FETCH the next cycle.
- Warm-up (WARMUP=8): feed nine 0x01 bytes from reset.
  - No pt_valid for the first eight, though pt_x follows 127, 191, 223, … .
  - pt_valid rises after the ninth with pt_x=254 (the eighth move gives 254; the ninth keeps 254), pt_y=0.
- run control:
  - Drop run in HOLD: pt_valid holds until pt_ready, then the block enters IDLE, rnd_ready=0, and the point is retained.
  - Re-raise run: the next point continues from the retained coordinates.
- Reset mid-operation: assert rst while in HOLD at point (63,63).
  - Next cycle: pt_valid=0, pt_x=pt_y=0, rej_cnt=0.
  - With WARMUP=8, the warm-up count restarts.
